// File: rtl/multicycle_seq_pkg.sv
// Shared encodings and constants for the multi-cycle instruction sequencer.
package multicycle_seq_pkg;

    localparam int STATE_W = 7;

    localparam logic [STATE_W-1:0] STATE_FETCH      = 7'b000_0001;
    localparam logic [STATE_W-1:0] STATE_FETCH_WAIT = 7'b000_0010;
    localparam logic [STATE_W-1:0] STATE_DECODE     = 7'b000_0100;
    localparam logic [STATE_W-1:0] STATE_EXECUTE    = 7'b000_1000;
    localparam logic [STATE_W-1:0] STATE_EXEC_WAIT  = 7'b001_0000;
    localparam logic [STATE_W-1:0] STATE_WRITE      = 7'b010_0000;
    localparam logic [STATE_W-1:0] STATE_FAULT      = 7'b100_0000;

    localparam int DEF_PC_W  = 32;
    localparam int DEF_CNT_W = 32;

    localparam int          PC_INC     = 4;
    // Low PC bits that are forced to zero on a redirect.
    localparam logic [1:0]  ALIGN_MASK = 2'b11;

endpackage

// File: rtl/multicycle_seq_wait_timer.sv
// Wait-state watchdog: counts cycles while enabled, cleared outside wait states.
// expired_o is combinational and rises in the TIMEOUT-th enabled cycle; TIMEOUT=0 never expires.
module wait_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    logic [TW-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of wait cycles already completed.
    assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q == TW'(LIM));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && !expired_o)
            cnt_d = cnt_q + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/multicycle_seq.sv
// PC owner and FETCH/DECODE/EXECUTE/WAIT/WRITE sequencer; all outputs registered, strobes one cycle wide.
// Waits on fetched / unit_accessed under a watchdog; halt holds in FETCH; FAULT is terminal until reset.
module multicycle_seq
    import multicycle_seq_pkg::*;
#(
    parameter int              PC_W     = DEF_PC_W,
    parameter int              N_UNIT   = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 1024,
    parameter int              CNT_W    = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               halt,
    output logic               fetch_order,
    output logic [PC_W-1:0]    fetch_pc,
    input  logic               fetched,
    output logic               dec_en,
    output logic               exe_en,
    input  logic [N_UNIT-1:0]  unit_sel,
    output logic [N_UNIT-1:0]  unit_order,
    input  logic [N_UNIT-1:0]  unit_accessed,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    target,
    input  logic               wb_req,
    output logic               reg_we,
    output logic               fault,
    output logic [PC_W-1:0]    fault_pc,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   instret_cnt,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [STATE_W-1:0] state
);
    logic [STATE_W-1:0] state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d, npc_q, npc_d, fault_pc_q, fault_pc_d;
    logic               wb_q, wb_d;
    logic [N_UNIT-1:0]  sel_q, sel_d, unit_order_q, unit_order_d;
    logic               fetch_order_q, fetch_order_d, dec_en_q, dec_en_d;
    logic               exe_en_q, exe_en_d, reg_we_q, reg_we_d, fault_q, fault_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d, instret_q, instret_d, stall_q, stall_d;
    logic               in_wait, expired;
    logic [N_UNIT-1:0]  sel_lowest;
    logic [PC_W-1:0]    redirect_pc;

    // Isolate the lowest set bit so a malformed multi-hot select still starts one unit.
    assign sel_lowest  = unit_sel & (~unit_sel + N_UNIT'(1));
    assign redirect_pc = {target[PC_W-1:2], target[1:0] & ~ALIGN_MASK};
    assign in_wait     = (state_q == STATE_FETCH_WAIT) || (state_q == STATE_EXEC_WAIT);

    wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk       (clk),
        .rstn      (rstn),
        .clr_i     (!in_wait),
        .en_i      (in_wait),
        .expired_o (expired)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        npc_d         = npc_q;
        wb_d          = wb_q;
        sel_d         = sel_q;
        fault_d       = fault_q;
        fault_pc_d    = fault_pc_q;
        fetch_order_d = 1'b0;
        dec_en_d      = 1'b0;
        exe_en_d      = 1'b0;
        unit_order_d  = '0;
        reg_we_d      = 1'b0;
        instret_d     = instret_q;
        cycle_d       = (state_q == STATE_FAULT) ? cycle_q : cycle_q + CNT_W'(1);
        stall_d       = in_wait ? stall_q + CNT_W'(1) : stall_q;

        case (state_q)
            STATE_FETCH: begin
                if (!halt) begin
                    fetch_order_d = 1'b1;
                    state_d       = STATE_FETCH_WAIT;
                end
            end
            STATE_FETCH_WAIT: begin
                if (fetched) begin
                    state_d = STATE_DECODE;
                end else if (expired) begin
                    state_d    = STATE_FAULT;
                    fault_d    = 1'b1;
                    fault_pc_d = pc_q;
                end
            end
            STATE_DECODE: begin
                dec_en_d = 1'b1;
                state_d  = STATE_EXECUTE;
            end
            STATE_EXECUTE: begin
                wb_d  = wb_req;
                npc_d = branch_taken ? redirect_pc : pc_q + PC_W'(PC_INC);
                if (unit_sel == '0) begin
                    exe_en_d = 1'b1;
                    state_d  = STATE_WRITE;
                end else begin
                    unit_order_d = sel_lowest;
                    sel_d        = sel_lowest;
                    state_d      = STATE_EXEC_WAIT;
                end
            end
            STATE_EXEC_WAIT: begin
                // Completion is checked first so it wins over a same-cycle timeout.
                if ((unit_accessed & sel_q) != '0) begin
                    state_d = STATE_WRITE;
                end else if (expired) begin
                    state_d    = STATE_FAULT;
                    fault_d    = 1'b1;
                    fault_pc_d = pc_q;
                end
            end
            STATE_WRITE: begin
                reg_we_d  = wb_q;
                pc_d      = npc_q;
                instret_d = instret_q + CNT_W'(1);
                state_d   = STATE_FETCH;
            end
            STATE_FAULT: begin
                state_d = STATE_FAULT;
            end
            default: begin
                state_d = STATE_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= STATE_FETCH;
            pc_q          <= RESET_PC;
            npc_q         <= RESET_PC;
            wb_q          <= 1'b0;
            sel_q         <= '0;
            fault_q       <= 1'b0;
            fault_pc_q    <= '0;
            fetch_order_q <= 1'b0;
            dec_en_q      <= 1'b0;
            exe_en_q      <= 1'b0;
            unit_order_q  <= '0;
            reg_we_q      <= 1'b0;
            cycle_q       <= '0;
            instret_q     <= '0;
            stall_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            npc_q         <= npc_d;
            wb_q          <= wb_d;
            sel_q         <= sel_d;
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
            fetch_order_q <= fetch_order_d;
            dec_en_q      <= dec_en_d;
            exe_en_q      <= exe_en_d;
            unit_order_q  <= unit_order_d;
            reg_we_q      <= reg_we_d;
            cycle_q       <= cycle_d;
            instret_q     <= instret_d;
            stall_q       <= stall_d;
        end
    end

    assign state       = state_q;
    assign fetch_pc    = pc_q;
    assign fetch_order = fetch_order_q;
    assign dec_en      = dec_en_q;
    assign exe_en      = exe_en_q;
    assign unit_order  = unit_order_q;
    assign reg_we      = reg_we_q;
    assign fault       = fault_q;
    assign fault_pc    = fault_pc_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
    assign stall_cnt   = stall_q;

endmodule
